cipher_frame_receiver: RTL and testbench
========================================

// Module: cipher_frame_receiver
// PURPOSE
//  Upstream feeder for the 7-bit decrypter. Deserialises encrypted 7-bit frames from a serial line.
//  Checks parity and framing, then holds each good frame, with the key it belongs to, in a 1-entry
//  output buffer. The decrypter consumes the buffer over a valid/ready handshake.
//  Its message/key inputs tie directly to rxMessage/rxKey.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range 4..255.
//  CNT_W          8  width of the bit-timing counter; must hold CLKS_PER_BIT-1.
// PORTS
//  clk            in   1  single clock; all state on rising edge
//  reset          in   1  synchronous, active-high reset
//  serialIn       in   1  async serial line; idles high
//  keyIn          in   7  new key value
//  keyLoad        in   1  1-cycle strobe: keyReg <= keyIn
//  rxMessage      out  7  encrypted message to decrypter (LSB = first data bit)
//  rxKey          out  7  key paired with rxMessage
//  rxValid        out  1  rxMessage/rxKey hold a frame
//  rxReady        in   1  consumer accepts when rxValid & rxReady
//  parityError    out  1  1-cycle pulse: frame dropped, bad parity
//  framingError   out  1  1-cycle pulse: frame dropped, stop bit = 0
//  overrun        out  1  1-cycle pulse: good frame dropped, buffer full
// BEHAVIOUR
//  Reset values:
//   rxMessage = 0, rxKey = 0, rxValid = 0, all error pulses = 0.
//   keyReg = 0, FSM = IDLE, sync flops = 1.
//  Input path:
//   serialIn passes through a 2-flop synchroniser (2 cycles latency); the FSM sees only the synced bit.
//  Frame format: start(0), d0..d6 LSB first, even parity (ones in d0..d6 + parity = even), stop(1).
//  FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
//   IDLE:      synced line = 0 -> START; cnt = 0.
//   START:     at cnt = CLKS_PER_BIT/2 - 1, sample. 1 -> glitch, back to IDLE (no flag). 0 -> DATA; cnt = 0, bitIdx = 0.
//   DATA:      at cnt = CLKS_PER_BIT-1, shift the sample into bit bitIdx. After bitIdx 6 -> PARITY.
//   PARITY:    at cnt = CLKS_PER_BIT-1, sample into parBit -> STOP.
//   STOP:      at cnt = CLKS_PER_BIT-1, sample the stop bit.
//    - stop = 0: framingError pulse, frame dropped -> WAIT_HIGH.
//    - stop = 1, parity bad: parityError pulse, frame dropped -> IDLE.
//    - stop = 1, parity good: commit -> IDLE.
//   WAIT_HIGH: stay until synced line = 1 -> IDLE. Prevents a break from restarting the FSM.
//   When both faults occur, framing takes precedence: only framingError pulses.
//  Commit, in the stop-sample cycle:
//   - buffer empty, or being accepted that same cycle (rxValid & rxReady):
//     rxMessage <= shifted data, rxKey <= keyReg, rxValid <= 1 on the next edge.
//     Simultaneous accept + commit produces no gap and no overrun.
//   - buffer full and not accepted: frame dropped, overrun pulse, old frame unchanged.
//  Latency: rxValid rises 1 cycle after the stop-bit sample edge.
//  Handshake:
//   rxMessage/rxKey stay stable while rxValid = 1.
//   Accept clears rxValid next edge unless a commit coincides.
//   rxReady is ignored while rxValid = 0.
//  Key:
//   keyLoad updates keyReg next edge and never alters an already-buffered rxKey.
//   keyLoad in the commit cycle: the frame takes the OLD keyReg.
//  Reset mid-frame: reset forces all reset values at once; the partial frame is lost and no error pulses.
//  Counter: cnt resets to 0 on each sample; it never wraps past CLKS_PER_BIT-1.
// TESTING
//  (CLKS_PER_BIT = 16 in all cases)
//  T1: keyLoad keyIn = 7'h2A, then send frame d = 7'h55 with parity 0.
//      -> rxValid = 1, rxMessage = 7'h55, rxKey = 7'h2A.
//  T2: send 7'h01 with parity 0 (odd total).
//      -> parityError pulses once, rxValid stays 0.
//  T3: send 7'h3C with stop = 0, then hold the line low 40 cycles.
//      -> framingError once; no new START until the line returns high.
//  T4: rxReady = 0, send 7'h11 then 7'h22.
//      -> overrun once; rxMessage stays 7'h11.
//      -> repeat with rxReady = 1 in the commit cycle: 7'h22 is loaded, no overrun.
//  T5: 4-cycle low glitch on an idle line -> FSM returns to IDLE, no pulses.
//      Reset asserted during DATA bit 3 -> all outputs 0 next edge, then a clean frame is received.

Source files
------------

// File: rtl/cipher_frame_receiver.sv
// ---------------------------------------------------------------------------
// cipher_frame_receiver
// Deserialises 7-bit encrypted frames from an asynchronous serial line
// (start, d0..d6 LSB first, even parity, stop). It checks parity and framing,
// then places each good frame in a 1-entry output buffer together with the
// key that was current when the frame was committed. The buffer is drained
// over a valid/ready handshake.
//
// Ports
//   clk           : single clock, all state on the rising edge
//   reset         : synchronous, active-high reset
//   serialIn      : asynchronous serial line, idles high
//   keyIn/keyLoad : keyLoad strobe loads keyIn into the key register
//   rxMessage     : buffered encrypted message (bit 0 = first data bit)
//   rxKey         : key paired with rxMessage
//   rxValid       : buffer holds a frame
//   rxReady       : consumer accepts when rxValid & rxReady
//   parityError   : 1-cycle pulse, frame dropped for bad parity
//   framingError  : 1-cycle pulse, frame dropped for stop bit = 0
//   overrun       : 1-cycle pulse, good frame dropped because buffer full
// ---------------------------------------------------------------------------
module cipher_frame_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serialIn,
    input  logic [6:0] keyIn,
    input  logic       keyLoad,
    output logic [6:0] rxMessage,
    output logic [6:0] rxKey,
    output logic       rxValid,
    input  logic       rxReady,
    output logic       parityError,
    output logic       framingError,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    // True when data plus parity bit carry an even number of ones.
    function automatic logic even_parity_ok(input logic [6:0] data, input logic par);
        return ~(^{data, par});
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [6:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [6:0]       key_q, key_d;
    logic [6:0]       rx_msg_q, rx_msg_d;
    logic [6:0]       rx_key_q, rx_key_d;
    logic             rx_valid_q, rx_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             framing_err_q, framing_err_d;
    logic             overrun_q, overrun_d;
    logic             commit_s;
    logic             line_s;

    // Synchronised line as seen by the FSM (second synchroniser stage).
    assign line_s = sync_q[1];

    // Next-state, sampling and output-buffer logic.
    always_comb begin
        state_d       = state_q;
        sync_d        = {sync_q[0], serialIn};
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        par_d         = par_q;
        key_d         = key_q;
        rx_msg_d      = rx_msg_q;
        rx_key_d      = rx_key_q;
        rx_valid_d    = rx_valid_q & ~rxReady;
        parity_err_d  = 1'b0;
        framing_err_d = 1'b0;
        overrun_d     = 1'b0;
        commit_s      = 1'b0;

        if (keyLoad) begin
            key_d = keyIn;
        end else begin
            key_d = key_q;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (!line_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                // Mid-start-bit sample rejects short low glitches silently.
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = 3'd0;
                    if (line_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d              = CNT_ZERO;
                    shift_d[bit_idx_q] = line_s;
                    if (bit_idx_q == 3'd6) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    par_d   = line_s;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                // Framing fault outranks parity fault.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (!line_s) begin
                        framing_err_d = 1'b1;
                        state_d       = ST_WAIT_HIGH;
                    end else if (!even_parity_ok(shift_q, par_q)) begin
                        parity_err_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        commit_s = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low break must not be taken as a new start bit.
                cnt_d = CNT_ZERO;
                if (line_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // A commit may land in the same cycle the old frame is accepted.
        if (commit_s) begin
            if (!rx_valid_q || rxReady) begin
                rx_msg_d   = shift_q;
                rx_key_d   = key_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            overrun_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sync_q        <= 2'b11;
            cnt_q         <= CNT_ZERO;
            bit_idx_q     <= 3'd0;
            shift_q       <= 7'd0;
            par_q         <= 1'b0;
            key_q         <= 7'd0;
            rx_msg_q      <= 7'd0;
            rx_key_q      <= 7'd0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            key_q         <= key_d;
            rx_msg_q      <= rx_msg_d;
            rx_key_q      <= rx_key_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rxMessage    = rx_msg_q;
    assign rxKey        = rx_key_q;
    assign rxValid      = rx_valid_q;
    assign parityError  = parity_err_q;
    assign framingError = framing_err_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_cipher_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_cipher_frame_receiver
// Directed frames with hand-computed expectations. Expected frames go into a
// scoreboard queue; a monitor on the falling edge pops and compares on every
// accepted handshake and counts error pulses.
// ---------------------------------------------------------------------------
module tb_cipher_frame_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       serialIn;
    logic [6:0] keyIn;
    logic       keyLoad;
    logic [6:0] rxMessage;
    logic [6:0] rxKey;
    logic       rxValid;
    logic       rxReady;
    logic       parityError;
    logic       framingError;
    logic       overrun;

    typedef struct packed {
        logic [6:0] msg;
        logic [6:0] key;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   par_cnt      = 0;
    int   frm_cnt      = 0;
    int   ovr_cnt      = 0;
    int   exp_par      = 0;
    int   exp_frm      = 0;
    int   exp_ovr      = 0;

    always #5 clk = ~clk;

    cipher_frame_receiver #(.CLKS_PER_BIT(16), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .serialIn     (serialIn),
        .keyIn        (keyIn),
        .keyLoad      (keyLoad),
        .rxMessage    (rxMessage),
        .rxKey        (rxKey),
        .rxValid      (rxValid),
        .rxReady      (rxReady),
        .parityError  (parityError),
        .framingError (framingError),
        .overrun      (overrun)
    );

    // Monitor: scoreboard pops on accept, buffer stability, pulse counting.
    initial begin : monitor
        logic        prev_hold;
        logic [13:0] prev_data;
        exp_t        e;
        prev_hold = 1'b0;
        prev_data = 14'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (parityError)  par_cnt++;
                if (framingError) frm_cnt++;
                if (overrun)      ovr_cnt++;
                if (prev_hold && rxValid) begin
                    tests_run++;
                    if ({rxMessage, rxKey} !== prev_data) begin
                        tests_failed++;
                        $display("FAIL buffer_stable: got %h expected %h", {rxMessage, rxKey}, prev_data);
                    end
                end
                if (rxValid && rxReady) begin
                    tests_run++;
                    if (sb_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL unexpected_frame: got msg=%h key=%h expected none", rxMessage, rxKey);
                    end else begin
                        e = sb_q.pop_front();
                        if (rxMessage !== e.msg || rxKey !== e.key) begin
                            tests_failed++;
                            $display("FAIL frame: got msg=%h key=%h expected msg=%h key=%h",
                                     rxMessage, rxKey, e.msg, e.key);
                        end
                    end
                end
                prev_hold = rxValid && !rxReady;
                prev_data = {rxMessage, rxKey};
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_pulses(input string name);
        chk({name, "_parity"},  par_cnt, exp_par);
        chk({name, "_framing"}, frm_cnt, exp_frm);
        chk({name, "_overrun"}, ovr_cnt, exp_ovr);
    endtask

    // Advance n rising edges, then step 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serialIn = b;
        tick(16);
    endtask

    // Full frame; the optional hook drives rxReady/keyLoad in the commit cycle
    // (the 11th clock of the stop bit, where the mid-bit sample lands).
    task automatic send_frame(input logic [6:0] d, input logic p, input logic s,
                              input logic hook_ready, input logic hook_load,
                              input logic [6:0] hook_key);
        logic saved_ready;
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(d[i]);
        send_bit(p);
        serialIn = s;
        tick(10);
        saved_ready = rxReady;
        if (hook_ready) rxReady = 1'b1;
        if (hook_load) begin
            keyIn   = hook_key;
            keyLoad = 1'b1;
        end
        tick(1);
        rxReady = saved_ready;
        keyLoad = 1'b0;
        tick(5);
        if (s) begin
            serialIn = 1'b1;
            tick(4);
        end
    endtask

    task automatic push(input logic [6:0] m, input logic [6:0] k);
        exp_t e;
        e.msg = m;
        e.key = k;
        sb_q.push_back(e);
    endtask

    initial begin : stimulus
        logic [6:0] partial;
        reset    = 1'b1;
        serialIn = 1'b1;
        keyIn    = 7'd0;
        keyLoad  = 1'b0;
        rxReady  = 1'b0;
        tick(3);
        chk("reset_valid",   int'(rxValid),   0);
        chk("reset_msg",     int'(rxMessage), 0);
        chk("reset_key",     int'(rxKey),     0);
        chk("reset_pulses",  int'({parityError, framingError, overrun}), 0);
        reset = 1'b0;
        tick(5);

        // T1: key load then good frame 0x55 (four ones, parity 0).
        keyIn   = 7'h2A;
        keyLoad = 1'b1;
        tick(1);
        keyLoad = 1'b0;
        push(7'h55, 7'h2A);
        send_frame(7'h55, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
        chk("t1_valid", int'(rxValid),   1);
        chk("t1_msg",   int'(rxMessage), 32'h55);
        chk("t1_key",   int'(rxKey),     32'h2A);
        rxReady = 1'b1;
        tick(2);
        chk("t1_valid_cleared", int'(rxValid), 0);
        chk_pulses("t1");

        // T2: 0x01 with parity 0 is odd overall.
        send_frame(7'h01, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
        tick(20);
        exp_par++;
        chk("t2_valid", int'(rxValid), 0);
        chk_pulses("t2");

        // T3: framing error followed by a 40-cycle break.
        send_frame(7'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        tick(40);
        serialIn = 1'b1;
        tick(200);
        exp_frm++;
        chk("t3_valid", int'(rxValid), 0);
        chk_pulses("t3");

        // T4: buffer full, second frame overruns.
        rxReady = 1'b0;
        push(7'h11, 7'h2A);
        send_frame(7'h11, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
        send_frame(7'h22, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
        exp_ovr++;
        chk("t4_msg_kept", int'(rxMessage), 32'h11);
        chk_pulses("t4");
        rxReady = 1'b1;
        tick(2);
        rxReady = 1'b0;

        // T4b: accept coincides with commit, no overrun.
        push(7'h11, 7'h2A);
        send_frame(7'h11, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
        push(7'h22, 7'h2A);
        send_frame(7'h22, 1'b0, 1'b1, 1'b1, 1'b0, 7'h00);
        chk("t4b_valid", int'(rxValid),   1);
        chk("t4b_msg",   int'(rxMessage), 32'h22);
        chk_pulses("t4b");
        rxReady = 1'b1;
        tick(2);

        // Key load in commit cycle: frame takes the old key, next frame the new.
        push(7'h7F, 7'h2A);
        send_frame(7'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 7'h15);
        push(7'h0E, 7'h15);
        send_frame(7'h0E, 1'b1, 1'b1, 1'b0, 1'b0, 7'h00);
        tick(2);
        chk_pulses("key");

        // T5: 4-cycle glitch, then a clean frame.
        serialIn = 1'b0;
        tick(4);
        serialIn = 1'b1;
        tick(30);
        chk("t5_glitch_valid", int'(rxValid), 0);
        chk_pulses("t5_glitch");
        push(7'h33, 7'h15);
        send_frame(7'h33, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
        tick(2);

        // T5b: buffer full, reset mid DATA bit 3, then a clean frame.
        rxReady = 1'b0;
        send_frame(7'h66, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
        chk("t5b_full", int'(rxValid), 1);
        partial = 7'h4B;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(partial[i]);
        serialIn = partial[3];
        tick(8);
        reset = 1'b1;
        tick(1);
        chk("t5b_rst_valid", int'(rxValid),   0);
        chk("t5b_rst_msg",   int'(rxMessage), 0);
        chk("t5b_rst_key",   int'(rxKey),     0);
        reset    = 1'b0;
        serialIn = 1'b1;
        rxReady  = 1'b1;
        tick(20);
        chk_pulses("t5b_rst");
        push(7'h4B, 7'h00);
        send_frame(7'h4B, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00);
        tick(4);
        chk_pulses("t5b_end");

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
